btn_event_decoder: RTL and testbench
====================================

Name: btn_event_decoder

Overview:
Consumes the raw button samples from the LED shift-register/button interface (btn_val qualified by btn_stb) and turns them into clean user events.
- Debounces the button.
- Times each press against a free-running ms tick derived from clk.
- Emits single-cycle event pulses: short press, long press, very-long-hold reset request.
- Keeps sticky pending bits that firmware reads and clears through the misc register block.
- Its rst_req output drives the sysmgr reset request.

Parameters:
TICK_DIV, 30720, clk cycles per ms tick (clk_sys = 30.72 MHz)
DEB_CNT, 4, consecutive differing btn_stb samples needed to change debounced state (range 1..15)
LONG_MS, 1000, hold time in ms at which a press becomes long
VLONG_MS, 5000, hold time in ms at which rst_req fires (must be > LONG_MS)
DBL_GAP_MS, 300, double-click window in ms (used only with optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
btn_val  in  1  raw button sample, 1 = pressed
btn_stb  in  1  btn_val valid this cycle
btn_state  out  1  debounced level
evt_short  out  1  1-cycle pulse, short press
evt_long  out  1  1-cycle pulse, long threshold reached
evt_double  out  1  1-cycle pulse, double click (0 when feature is off)
rst_req  out  1  1-cycle pulse, very-long hold
evt_pending  out  4  sticky flags: [0] short, [1] long, [2] double, [3] rst
evt_clr  in  4  per-bit clear of evt_pending

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high. On rst:
  - all outputs 0; prescaler 0, debounce count 0, hold_cnt 0, FSM IDLE.
  - A button held through reset must debounce again and is treated as a new press.
- Prescaler:
  - counts 0..TICK_DIV-1; tick = 1 for one cycle at wrap.
  - first tick arrives TICK_DIV cycles after reset release.
- Debounce:
  - evaluated only on cycles with btn_stb = 1.
  - btn_val != btn_state increments deb_cnt; btn_val == btn_state clears it.
  - When the increment would reach DEB_CNT: btn_state toggles on the next edge and deb_cnt clears.
  - btn_stb low holds deb_cnt unchanged.
- hold_cnt:
  - 16-bit; cleared on press; +1 per tick while not IDLE.
  - saturates at 65535, no wrap.
- FSM states: IDLE, PRESSED, LONG_HELD (+ WAIT_DBL, PRESSED2 with the optional feature).
  - IDLE: btn_state rising → PRESSED, hold_cnt = 0.
  - PRESSED:
    - btn_state falling → evt_short, go to IDLE.
    - tick with hold_cnt+1 == LONG_MS → evt_long, go to LONG_HELD.
  - LONG_HELD:
    - tick with hold_cnt+1 == VLONG_MS → rst_req once per press; stay in LONG_HELD.
    - btn_state falling → IDLE with no further event.
- Simultaneous release and threshold tick in the same cycle: release wins, judged on the pre-increment hold_cnt (release in PRESSED → evt_short only).
- Event pulses are registered, asserting 1 cycle after the causing condition. At most one event pulse is asserted per cycle.
- evt_pending:
  - bit set the cycle after its pulse.
  - evt_clr bit clears it.
  - set and clear in the same cycle → stays set.

Optional Feature:
Macro: BTN_DBLCLICK_EN.
- Defined:
  - PRESSED release goes to WAIT_DBL (hold_cnt = 0, counting ticks) instead of emitting evt_short.
  - WAIT_DBL, new press before DBL_GAP_MS ticks elapse → PRESSED2, hold_cnt = 0.
  - WAIT_DBL, gap expires (tick with hold_cnt+1 == DBL_GAP_MS) → evt_short, IDLE. evt_short is therefore delayed by DBL_GAP_MS.
  - PRESSED2, release before LONG_MS → evt_double, IDLE.
  - PRESSED2, reaching LONG_MS → evt_long and LONG_HELD. The pending short is discarded.
- Undefined: states WAIT_DBL and PRESSED2 do not exist; evt_double and evt_pending[2] are constant 0.

Test Plan:
(Bench params: TICK_DIV=4, DEB_CNT=3, LONG_MS=10, VLONG_MS=20, DBL_GAP_MS=5, btn_stb every 2 cycles.)
- Glitch rejection: btn_val=1 for 2 strobes then 0 → btn_state stays 0, no events, deb_cnt back to 0.
- Short press: btn_val=1 for 3 strobes, hold 5 ticks, release for 3 strobes → btn_state pulses high; exactly one evt_short (feature off); evt_pending = 4'b0001; evt_clr[0] → 4'b0000.
- Long + reset: hold 25 ticks → evt_long at tick 10, rst_req once at tick 20, none on release; evt_pending = 4'b1010.
- Boundary: release debounced on the same cycle as the tick where hold_cnt+1 == 10 → evt_short only, no evt_long.
- Set/clear race: evt_clr[0]=1 in the same cycle evt_pending[0] is set → bit remains 1. Reset asserted mid-press at tick 7 → all outputs 0, no event after release.
- With BTN_DBLCLICK_EN: two 3-tick presses separated by a 2-tick gap → one evt_double, no evt_short. A single press followed by a 5-tick gap → evt_short 5 ticks after release.

Source files
------------

// File: rtl/btn_event_decoder.sv
// btn_event_decoder: debounces the raw button sample stream, times each press
// against a ms tick and produces short/long/very-long-hold event pulses plus
// sticky pending flags for firmware.
// Optional double-click detection is compiled in with `define BTN_DBLCLICK_EN.
`timescale 1ns/1ps
module btn_event_decoder #(
  parameter int TICK_DIV   = 30720,
  parameter int DEB_CNT    = 4,
  parameter int LONG_MS    = 1000,
  parameter int VLONG_MS   = 5000,
  parameter int DBL_GAP_MS = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_val,
  input  logic       btn_stb,
  output logic       btn_state,
  output logic       evt_short,
  output logic       evt_long,
  output logic       evt_double,
  output logic       rst_req,
  output logic [3:0] evt_pending,
  input  logic [3:0] evt_clr
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0]      DEB_TGT   = 4'(DEB_CNT);
  localparam logic [16:0]     LONG_TGT  = 17'(LONG_MS);
  localparam logic [16:0]     VLONG_TGT = 17'(VLONG_MS);
`ifdef BTN_DBLCLICK_EN
  localparam logic [16:0]     DBL_TGT   = 17'(DBL_GAP_MS);
`endif

  // Reject parameter sets the counters and FSM cannot honour.
  if (DEB_CNT < 1 || DEB_CNT > 15 || LONG_MS < 1 || VLONG_MS <= LONG_MS ||
      VLONG_MS > 65535 || DBL_GAP_MS < 1) begin : g_bad_cfg
    $error("btn_event_decoder: invalid parameter set");
  end

`ifdef BTN_DBLCLICK_EN
  typedef enum logic [2:0] {S_IDLE, S_PRESSED, S_LONG_HELD, S_WAIT_DBL, S_PRESSED2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_LONG_HELD} state_t;
`endif

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [3:0]    deb_cnt_q, deb_cnt_d;
  logic          btn_state_q, btn_state_d;
  logic          rise, fall;
  logic [15:0]   hold_q, hold_d;
  logic [16:0]   hold_inc;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          dbl_q, dbl_d;
  logic          rreq_q, rreq_d;
  logic [3:0]    pend_q, pend_d;

  // Hold time never wraps: a stuck button must not re-trigger thresholds.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Free-running ms prescaler; tick marks the last cycle of each period.
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Debounce: only strobed samples count; a matching sample restarts the run.
  always_comb begin
    deb_cnt_d   = deb_cnt_q;
    btn_state_d = btn_state_q;
    if (btn_stb) begin
      if (btn_val == btn_state_q) begin
        deb_cnt_d = '0;
      end else if (deb_cnt_q + 4'd1 == DEB_TGT) begin
        deb_cnt_d   = '0;
        btn_state_d = ~btn_state_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 4'd1;
      end
    end
  end

  // Edges are taken from the debounce decision so the FSM moves with btn_state.
  assign rise     = btn_state_d & ~btn_state_q;
  assign fall     = ~btn_state_d & btn_state_q;
  assign hold_inc = {1'b0, hold_q} + 17'd1;

  // Press FSM: release is tested before any threshold so it wins a same-cycle tie.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    rreq_d  = 1'b0;
    if (state_q != S_IDLE && tick) hold_d = sat_inc16(hold_q);
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_PRESSED;
          hold_d  = '0;
        end
      end
      S_PRESSED: begin
        if (fall) begin
`ifdef BTN_DBLCLICK_EN
          state_d = S_WAIT_DBL;
          hold_d  = '0;
`else
          state_d = S_IDLE;
          short_d = 1'b1;
`endif
        end else if (tick && hold_inc == LONG_TGT) begin
          state_d = S_LONG_HELD;
          long_d  = 1'b1;
        end
      end
      S_LONG_HELD: begin
        if (fall) begin
          state_d = S_IDLE;
        end else if (tick && hold_inc == VLONG_TGT) begin
          rreq_d = 1'b1;
        end
      end
`ifdef BTN_DBLCLICK_EN
      S_WAIT_DBL: begin
        if (rise) begin
          state_d = S_PRESSED2;
          hold_d  = '0;
        end else if (tick && hold_inc == DBL_TGT) begin
          state_d = S_IDLE;
          short_d = 1'b1;
        end
      end
      S_PRESSED2: begin
        if (fall) begin
          state_d = S_IDLE;
          dbl_d   = 1'b1;
        end else if (tick && hold_inc == LONG_TGT) begin
          state_d = S_LONG_HELD;
          long_d  = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky flags: a new pulse outranks a clear arriving in the same cycle.
  always_comb begin
    pend_d = (pend_q & ~evt_clr) | {rreq_q, dbl_q, long_q, short_q};
  end

  // State register for prescaler, debounce, FSM, event pulses and pending flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      deb_cnt_q   <= '0;
      btn_state_q <= 1'b0;
      state_q     <= S_IDLE;
      hold_q      <= '0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      dbl_q       <= 1'b0;
      rreq_q      <= 1'b0;
      pend_q      <= '0;
    end else begin
      presc_q     <= presc_d;
      deb_cnt_q   <= deb_cnt_d;
      btn_state_q <= btn_state_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      short_q     <= short_d;
      long_q      <= long_d;
      dbl_q       <= dbl_d;
      rreq_q      <= rreq_d;
      pend_q      <= pend_d;
    end
  end

  assign btn_state   = btn_state_q;
  assign evt_short   = short_q;
  assign evt_long    = long_q;
  assign evt_double  = dbl_q;
  assign rst_req     = rreq_q;
  assign evt_pending = pend_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Testbench for btn_event_decoder: table-driven debounce vectors plus
// hand-written multi-cycle sequences; event pulses checked by a scoreboard.
`timescale 1ns/1ps
module tb_btn_event_decoder;

  localparam int TICK_DIV   = 4;
  localparam int DEB_CNT    = 3;
  localparam int LONG_MS    = 10;
  localparam int VLONG_MS   = 20;
  localparam int DBL_GAP_MS = 5;

  localparam logic [3:0] K_SHORT = 4'b0001;
  localparam logic [3:0] K_LONG  = 4'b0010;
  localparam logic [3:0] K_DBL   = 4'b0100;
  localparam logic [3:0] K_RST   = 4'b1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_val = 1'b0;
  logic       btn_stb = 1'b0;
  logic [3:0] evt_clr = 4'b0;
  logic       btn_state, evt_short, evt_long, evt_double, rst_req;
  logic [3:0] evt_pending;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] kind;
    int         at;
  } exp_t;
  exp_t sbq[$];

  typedef struct packed {
    logic val;
    logic st;
  } vec_t;

  btn_event_decoder #(
    .TICK_DIV(TICK_DIV), .DEB_CNT(DEB_CNT), .LONG_MS(LONG_MS),
    .VLONG_MS(VLONG_MS), .DBL_GAP_MS(DBL_GAP_MS)
  ) dut (
    .clk(clk), .rst(rst), .btn_val(btn_val), .btn_stb(btn_stb),
    .btn_state(btn_state), .evt_short(evt_short), .evt_long(evt_long),
    .evt_double(evt_double), .rst_req(rst_req), .evt_pending(evt_pending),
    .evt_clr(evt_clr)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; equals the DUT prescaler phase.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] kind, input int at);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    sbq.push_back(e);
  endtask

  // Scoreboard consumer: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    logic [3:0] ev;
    ev = {rst_req, evt_double, evt_long, evt_short};
    if (!rst && ev != 4'b0) begin
      if (sbq.size() == 0) begin
        check("unexpected_event", 32'(ev), 32'(0));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("event_kind", 32'(ev), 32'(e.kind));
        check("event_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    btn_stb = cyc[0];
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic step_until(input int c);
    while (cyc < c) step();
  endtask

  // Hold btn_val at v for DEB_CNT strobes; returns the cycle btn_state changes.
  task automatic apply_level(input logic v, output int chg);
    int n = 0;
    btn_val = v;
    while (n < DEB_CNT) begin
      if (btn_stb) n++;
      step();
    end
    chg = cyc;
    check(v ? "deb_press" : "deb_release", 32'(btn_state), 32'(v));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      step();
      n++;
    end
    step_n(2);
    check("scoreboard_empty", 32'(sbq.size()), 32'(0));
  endtask

  task automatic clear_all();
    evt_clr = 4'hF;
    step();
    evt_clr = 4'h0;
    check("pend_cleared", 32'(evt_pending), 32'(0));
  endtask

  function automatic int first_tick(input int c);
    int t = c;
    while (t % TICK_DIV != TICK_DIV - 1) t++;
    return t;
  endfunction

  // Cycle at which evt_short appears for a release seen at cycle chg.
  function automatic int short_at(input int chg);
`ifdef BTN_DBLCLICK_EN
    return first_tick(chg) + (DBL_GAP_MS - 1) * TICK_DIV + 1;
`else
    return chg;
`endif
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rows [17];
    logic prev;
    int   chg, t1, t10, p;

    rows = '{
      '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b0, 1'b0},
      '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b0, 1'b0},
      '{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b1},
      '{1'b1, 1'b1}, '{1'b1, 1'b1}, '{1'b1, 1'b1},
      '{1'b0, 1'b1}, '{1'b1, 1'b1}, '{1'b0, 1'b1},
      '{1'b0, 1'b1}, '{1'b0, 1'b0}
    };

    // Reset state
    rst = 1'b1;
    step_n(3);
    check("rst_btn_state", 32'(btn_state), 32'(0));
    check("rst_events", 32'({rst_req, evt_double, evt_long, evt_short}), 32'(0));
    check("rst_pending", 32'(evt_pending), 32'(0));
    rst = 1'b0;

    // Glitch rejection, run-clear and a short press from the vector table
    prev = 1'b0;
    for (int i = 0; i < 17; i++) begin
      while (!btn_stb) step();
      btn_val = rows[i].val;
      if (prev && !rows[i].st) push(K_SHORT, short_at(cyc + 1));
      step();
      check($sformatf("table_row%0d", i), 32'(btn_state), 32'(rows[i].st));
      prev = rows[i].st;
    end
    drain(60);
    check("pend_short", 32'(evt_pending), 32'(4'b0001));
    evt_clr = 4'b0001;
    step();
    evt_clr = 4'b0000;
    check("pend_short_clr", 32'(evt_pending), 32'(0));

    // Long hold through the very-long threshold, silent release
    apply_level(1'b1, chg);
    t1 = first_tick(chg);
    push(K_LONG, t1 + (LONG_MS - 1) * TICK_DIV + 1);
    push(K_RST,  t1 + (VLONG_MS - 1) * TICK_DIV + 1);
    step_until(t1 + 25 * TICK_DIV);
    apply_level(1'b0, chg);
    drain(20);
    step_n(8);
    check("pend_long_rst", 32'(evt_pending), 32'(4'b1010));
    clear_all();

    // Release decided on the very tick that would make the press long
    apply_level(1'b1, chg);
    t1  = first_tick(chg);
    t10 = t1 + (LONG_MS - 1) * TICK_DIV;
    step_until(t10 - 2 * (DEB_CNT - 1));
    push(K_SHORT, short_at(t10 + 1));
    apply_level(1'b0, chg);
    drain(40);
    check("pend_boundary", 32'(evt_pending), 32'(4'b0001));
    clear_all();

    // Clear request in the same cycle the pending bit is being set
    apply_level(1'b1, chg);
    step_n(6);
    apply_level(1'b0, chg);
    p = short_at(chg);
    push(K_SHORT, p);
    step_until(p);
    evt_clr = 4'b0001;
    step();
    evt_clr = 4'b0000;
    check("pend_set_clr_race", 32'(evt_pending[0]), 32'(1));
    drain(4);

    // Reset mid-press at the 7th tick, button released during reset
    apply_level(1'b1, chg);
    t1 = first_tick(chg);
    step_until(t1 + 6 * TICK_DIV);
    rst = 1'b1;
    step();
    check("midrst_btn_state", 32'(btn_state), 32'(0));
    check("midrst_events", 32'({rst_req, evt_double, evt_long, evt_short}), 32'(0));
    check("midrst_pending", 32'(evt_pending), 32'(0));
    btn_val = 1'b0;
    step_n(3);
    rst = 1'b0;
    step_n(100);
    check("midrst_after_btn", 32'(btn_state), 32'(0));
    check("midrst_after_pend", 32'(evt_pending), 32'(0));

    // Button held through reset debounces again as a new press
    apply_level(1'b1, chg);
    step_n(4);
    rst = 1'b1;
    step_n(2);
    check("heldrst_btn_state", 32'(btn_state), 32'(0));
    rst = 1'b0;
    apply_level(1'b1, chg);
    step_n(6);
    apply_level(1'b0, chg);
    push(K_SHORT, short_at(chg));
    drain(40);
    check("heldrst_pend", 32'(evt_pending), 32'(4'b0001));
    clear_all();

`ifdef BTN_DBLCLICK_EN
    // Two short presses inside the gap window form a double click
    apply_level(1'b1, chg);
    step_n(3 * TICK_DIV);
    apply_level(1'b0, chg);
    step_n(3);
    apply_level(1'b1, chg);
    step_n(3 * TICK_DIV);
    apply_level(1'b0, chg);
    push(K_DBL, chg);
    drain(10);
    check("pend_double", 32'(evt_pending), 32'(4'b0100));

    // A lone press reports short only after the gap expires
    apply_level(1'b1, chg);
    step_n(3 * TICK_DIV);
    apply_level(1'b0, chg);
    push(K_SHORT, short_at(chg));
    drain(40);
    check("pend_dbl_short", 32'(evt_pending), 32'(4'b0101));
    clear_all();
`endif

    step_n(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
